text_console_writer: RTL and testbench

- Fills the 80x30 character text buffer that the VGA painter renders. It is the write side of the text buffer interface, driven by a byte-wide character stream from the CPU/MMIO side.
- Keeps a cursor and interprets printable ASCII plus a small set of control codes.
- Performs hardware scroll and screen clear through one write port and one synchronous read port on the buffer RAM.

---
 rtl/text_pkg.sv | 28 ++
 rtl/cursor_addr.sv | 15 +
 rtl/text_console_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants, control codes and state encoding for the text console writer.
package text_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int TEXT_DEPTH = COLS * ROWS;

    localparam logic [6:0] BLANK = 7'h20;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_CR = 7'h0D;
    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_FF = 7'h0C;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        CLR_ALL = 3'd1,
        IDLE    = 3'd2,
        WRITE   = 3'd3,
        SCR_RD  = 3'd4,
        SCR_WR  = 3'd5,
        CLR_ROW = 3'd6
    } console_state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/cursor_addr.sv
// Linear text buffer address of a (row, col) cursor position.
module cursor_addr #(
    parameter int AW = 12
) (
    input  logic [4:0]    row,
    input  logic [6:0]    col,
    output logic [AW-1:0] addr
);

    // row*80 built as row*64 + row*16 so no multiplier is inferred
    assign addr = {{(AW-11){1'b0}}, row, 6'b000000}
                + {{(AW-9){1'b0}}, row, 4'b0000}
                + {{(AW-7){1'b0}}, col};

endmodule

// File: rtl/text_console_writer.sv
// Write side of the 80x30 text buffer: cursor tracking, control codes,
// hardware scroll and clear through one write port and one sync read port.
module text_console_writer
    import text_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    char_i,
    input  logic          char_valid,
    output logic          char_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [6:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_A    = AW'(TEXT_DEPTH - 1);
    localparam logic [AW-1:0] ROW_CLR_A = AW'(TEXT_DEPTH - COLS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
    localparam logic [DW-1:0] BLANK_W   = {{(DW-7){1'b0}}, BLANK};

    console_state_t state_r;
    logic [6:0]    col_r;
    logic [4:0]    row_r;
    logic [AW-1:0] cnt_r;
    logic          is_bs_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [AW-1:0] raddr_r;
    logic          ready_r;
    logic          busy_r;

    logic [6:0]    code_s;
    logic          accept_s;
    logic [6:0]    addr_col_s;
    logic [AW-1:0] cur_addr_s;
    logic          unused_bit_s;

    assign code_s       = char_i[6:0];
    assign unused_bit_s = char_i[7];
    assign accept_s     = char_valid & ready_r;

    // Backspace writes the cell left of the cursor; everything else the cursor cell
    always_comb begin
        addr_col_s = col_r;
        if ((state_r == IDLE) && (code_s == CH_BS) && (col_r != 7'd0)) begin
            addr_col_s = col_r - 7'd1;
        end else begin
            addr_col_s = col_r;
        end
    end

    cursor_addr #(.AW(AW)) u_cursor_addr (
        .row  (row_r),
        .col  (addr_col_s),
        .addr (cur_addr_s)
    );

    // Console state machine with registered RAM, handshake and status outputs.
    // The scroll read address runs one word ahead (parked at COLS otherwise) so
    // the read data is already on ram_rdata when SCR_WR's write data is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= INIT;
            col_r   <= 7'd0;
            row_r   <= 5'd0;
            cnt_r   <= '0;
            is_bs_r <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            raddr_r <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                INIT: begin
                    state_r <= CLR_ALL;
                    cnt_r   <= '0;
                    we_r    <= 1'b1;
                    addr_r  <= '0;
                    wdata_r <= BLANK_W;
                    raddr_r <= COLS_A;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                end
                CLR_ALL: begin
                    if (cnt_r == LAST_A) begin
                        state_r <= IDLE;
                        we_r    <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        col_r   <= 7'd0;
                        row_r   <= 5'd0;
                    end else begin
                        cnt_r  <= cnt_r + 12'd1;
                        addr_r <= cnt_r + 12'd1;
                        we_r   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        if (is_printable(code_s)) begin
                            state_r <= WRITE;
                            we_r    <= 1'b1;
                            addr_r  <= cur_addr_s;
                            wdata_r <= {{(DW-7){1'b0}}, code_s};
                            ready_r <= 1'b0;
                            is_bs_r <= 1'b0;
                        end else if (code_s == CH_LF) begin
                            col_r <= 7'd0;
                            if (row_r == LAST_ROW) begin
                                state_r <= SCR_RD;
                                cnt_r   <= COLS_A;
                                ready_r <= 1'b0;
                                busy_r  <= 1'b1;
                            end else begin
                                row_r <= row_r + 5'd1;
                            end
                        end else if (code_s == CH_CR) begin
                            col_r <= 7'd0;
                        end else if ((code_s == CH_BS) && (col_r != 7'd0)) begin
                            col_r   <= col_r - 7'd1;
                            state_r <= WRITE;
                            we_r    <= 1'b1;
                            addr_r  <= cur_addr_s;
                            wdata_r <= BLANK_W;
                            ready_r <= 1'b0;
                            is_bs_r <= 1'b1;
                        end else if (code_s == CH_FF) begin
                            state_r <= CLR_ALL;
                            cnt_r   <= '0;
                            we_r    <= 1'b1;
                            addr_r  <= '0;
                            wdata_r <= BLANK_W;
                            raddr_r <= COLS_A;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            we_r <= 1'b0;
                        end
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                WRITE: begin
                    we_r <= 1'b0;
                    if (is_bs_r) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else if (col_r != LAST_COL) begin
                        col_r   <= col_r + 7'd1;
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else if (row_r != LAST_ROW) begin
                        col_r   <= 7'd0;
                        row_r   <= row_r + 5'd1;
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        col_r   <= 7'd0;
                        state_r <= SCR_RD;
                        cnt_r   <= COLS_A;
                        busy_r  <= 1'b1;
                    end
                end
                SCR_RD: begin
                    state_r <= SCR_WR;
                    we_r    <= 1'b1;
                    addr_r  <= cnt_r - COLS_A;
                    wdata_r <= ram_rdata;
                    raddr_r <= (cnt_r == LAST_A) ? COLS_A : (cnt_r + 12'd1);
                end
                SCR_WR: begin
                    if (cnt_r == LAST_A) begin
                        state_r <= CLR_ROW;
                        we_r    <= 1'b1;
                        addr_r  <= ROW_CLR_A;
                        wdata_r <= BLANK_W;
                        cnt_r   <= ROW_CLR_A;
                    end else begin
                        state_r <= SCR_RD;
                        we_r    <= 1'b0;
                        cnt_r   <= cnt_r + 12'd1;
                    end
                end
                CLR_ROW: begin
                    if (cnt_r == LAST_A) begin
                        state_r <= IDLE;
                        we_r    <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + 12'd1;
                        addr_r <= cnt_r + 12'd1;
                        we_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= INIT;
                    we_r    <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign char_ready = ready_r;
    assign ram_we     = we_r;
    assign ram_addr   = addr_r;
    assign ram_wdata  = wdata_r;
    assign ram_raddr  = raddr_r;
    assign cursor_col = col_r;
    assign cursor_row = row_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer with a 1-cycle synchronous RAM model.
module tb_text_console_writer;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    char_i = 8'h00;
    logic          char_valid = 1'b0;
    logic          char_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [6:0]    cursor_col;
    logic [4:0]    cursor_row;
    logic          busy;

    logic [DW-1:0] mem [0:2399];
    logic          preload = 1'b0;
    logic          sb_on = 1'b1;
    wr_t           exp_q [$];
    wr_t           e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            wr_cnt = 0;

    text_console_writer #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_i     (char_i),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 2400; k++) mem[k] <= 32'(k + 1000);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    // Scoreboard: every write strobe pops one expected (addr, data)
    always @(negedge clk) begin
        if (!reset && ram_we) begin
            wr_cnt++;
            if (sb_on) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_write addr=%0d data=%h", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== e.addr || ram_wdata !== e.data) begin
                        n_err++;
                        $display("FAIL sb_write got addr=%0d data=%h want addr=%0d data=%h",
                                 ram_addr, ram_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int a, input int d);
        exp_q.push_back('{addr: AW'(a), data: DW'(d)});
    endtask

    task automatic send_char(input logic [7:0] c);
        int t;
        t = 0;
        @(negedge clk);
        while (!char_ready && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (!char_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout char=%h ready=%b want 1", c, char_ready);
        end
        char_i = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        int t;
        int w0;
        reset = 1'b1;
        char_valid = 1'b0;
        exp_q.delete();
        sb_on = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ram_we, busy, char_ready, ram_addr, ram_wdata, ram_raddr, cursor_row, cursor_col}
            !== {1'b0, 1'b1, 1'b0, 12'd0, 32'd0, 12'd0, 5'd0, 7'd0}) begin
            n_err++;
            $display("FAIL %s_reset_state we=%b busy=%b rdy=%b addr=%0d wd=%h ra=%0d cur=(%0d,%0d) want 0,1,0,0,0,0,(0,0)",
                     tag, ram_we, busy, char_ready, ram_addr, ram_wdata, ram_raddr, cursor_row, cursor_col);
        end
        for (int k = 0; k < 2400; k++) push_exp(k, 32'h20);
        w0 = wr_cnt;
        reset = 1'b0;
        t = 0;
        while (!char_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (wr_cnt - w0 != 2400 || exp_q.size() != 0 || cursor_row !== 5'd0 ||
            cursor_col !== 7'd0 || char_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_clear writes=%0d left=%0d cur=(%0d,%0d) rdy=%b busy=%b want 2400,0,(0,0),1,0",
                     tag, wr_cnt - w0, exp_q.size(), cursor_row, cursor_col, char_ready, busy);
        end
    endtask

    task automatic test_single_char();
        push_exp(0, 32'h41);
        send_char(8'h41);
        n_cmp++;
        if (char_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready_drop ready=%b want 0", char_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_after rdy=%b cur=(%0d,%0d) left=%0d want 1,(0,1),0",
                     char_ready, cursor_row, cursor_col, exp_q.size());
        end
    endtask

    task automatic test_line_wrap();
        logic [7:0] c;
        int w0;
        send_char(8'h0D);
        for (int i = 0; i < 81; i++) begin
            c = 8'(8'h21 + (i % 94));
            push_exp(i, 32'(c));
            send_char(c);
            if (i == 79) begin
                @(negedge clk);
                n_cmp++;
                if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
                    n_err++;
                    $display("FAIL wrap_cursor cur=(%0d,%0d) want (1,0)", cursor_row, cursor_col);
                end
            end
        end
        @(negedge clk);
        w0 = wr_cnt;
        send_char(8'h0D);
        send_char(8'h0A);
        @(negedge clk);
        n_cmp++;
        if (wr_cnt != w0 || cursor_row !== 5'd2 || cursor_col !== 7'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL crlf writes=%0d cur=(%0d,%0d) left=%0d want 0,(2,0),0",
                     wr_cnt - w0, cursor_row, cursor_col, exp_q.size());
        end
    endtask

    task automatic test_backspace();
        int w0;
        for (int i = 0; i < 5; i++) begin
            push_exp(160 + i, 32'h61 + i);
            send_char(8'(8'h61 + i));
        end
        @(negedge clk);
        push_exp(164, 32'h20);
        send_char(8'h08);
        n_cmp++;
        if (char_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bs_ready_drop ready=%b want 0", char_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cursor_row !== 5'd2 || cursor_col !== 7'd4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bs_cursor cur=(%0d,%0d) left=%0d want (2,4),0", cursor_row, cursor_col, exp_q.size());
        end
        send_char(8'h0D);
        w0 = wr_cnt;
        send_char(8'h08);
        n_cmp++;
        if (char_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bs_col0_ready ready=%b want 1", char_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_cnt != w0 || cursor_row !== 5'd2 || cursor_col !== 7'd0) begin
            n_err++;
            $display("FAIL bs_col0 writes=%0d cur=(%0d,%0d) want 0,(2,0)", wr_cnt - w0, cursor_row, cursor_col);
        end
    endtask

    task automatic test_scroll();
        int cyc;
        for (int i = 0; i < 27; i++) send_char(8'h0A);
        for (int i = 0; i < 79; i++) begin
            push_exp(2320 + i, 32'h30 + (i % 10));
            send_char(8'(8'h30 + (i % 10)));
        end
        @(negedge clk);
        n_cmp++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd79) begin
            n_err++;
            $display("FAIL scroll_setup cur=(%0d,%0d) want (29,79)", cursor_row, cursor_col);
        end
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        push_exp(2399, 32'h5A);
        for (int k = 0; k < 2320; k++) push_exp(k, (k + 80 == 2399) ? 32'h5A : (k + 80 + 1000));
        for (int k = 2320; k < 2400; k++) push_exp(k, 32'h20);
        send_char(8'h5A);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 6000) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != 4720) begin
            n_err++;
            $display("FAIL scroll_busy_cycles got=%0d want 4720", cyc);
        end
        n_cmp++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd0 || char_ready !== 1'b1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scroll_end cur=(%0d,%0d) rdy=%b left=%0d want (29,0),1,0",
                     cursor_row, cursor_col, char_ready, exp_q.size());
        end
    endtask

    task automatic test_ff_held_valid();
        int t;
        for (int k = 0; k < 2400; k++) push_exp(k, 32'h20);
        push_exp(0, 32'h51);
        @(negedge clk);
        char_i = 8'h0C;
        char_valid = 1'b1;
        @(negedge clk);
        char_i = 8'h51;
        n_cmp++;
        if (char_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ff_start rdy=%b busy=%b want 0,1", char_ready, busy);
        end
        t = 0;
        while (!char_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        char_valid = 1'b0;
        n_cmp++;
        if (t != 2400) begin
            n_err++;
            $display("FAIL ff_held_wait got=%0d want 2400", t);
        end
        @(negedge clk);
        n_cmp++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ff_held_char cur=(%0d,%0d) left=%0d want (0,1),0", cursor_row, cursor_col, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_scroll();
        int t;
        sb_on = 1'b0;
        for (int i = 0; i < 30; i++) send_char(8'h0A);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL lf_scroll_busy busy=%b want 1", busy);
        end
        repeat (200) @(negedge clk);
        t = 0;
        while (!ram_we && t < 4) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_we !== 1'b0 || busy !== 1'b1 || char_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_abort we=%b busy=%b rdy=%b want 0,1,0", ram_we, busy, char_ready);
        end
        test_reset("abort");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset("por");
        test_single_char();
        test_line_wrap();
        test_backspace();
        test_scroll();
        test_ff_held_valid();
        test_reset_mid_scroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
